wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Captures results from both writeback lanes of the arithmetic execute stage into a small FIFO. Presents the head entry one nibble at a time on the board's 4-bit LED output. It sits directly downstream of the writeback ports and replaces direct LED observation of the live `wb` data. Results can be stepped through after the fact, in program order per cycle (lane 0 before lane 1), with loss flagged.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥4.
- `TAG_W`, 6, physical destination tag width; ≤8.

Ports:
- `clk`, in, 1, single core clock.
- `reset`, in, 1, asynchronous, active-low.
- `wb0_valid`, in, 1, lane 0 writeback valid.
- `wb0_data`, in, 32, lane 0 result.
- `wb0_tag`, in, TAG_W, lane 0 physical destination.
- `wb1_valid`, in, 1, lane 1 writeback valid.
- `wb1_data`, in, 32, lane 1 result.
- `wb1_tag`, in, TAG_W, lane 1 physical destination.
- `pop`, in, 1, level from a debounced button; each rising edge pops one entry.
- `switches`, in, 4, display select.
- `r1`, out, 4, registered display nibble.
- `empty`, out, 1, count==0.
- `full`, out, 1, count==DEPTH.
- `count`, out, $clog2(DEPTH)+1, occupied entries.
- `overflow`, out, 1, sticky; set when any valid writeback is dropped.

## Operation
- Entry layout: {tag zero-extended to 8, data[31:0]}, plus timestamp when configured.
- Push:
  - space = DEPTH − count, evaluated before this cycle's pop; a same-cycle pop does not create space.
  - Lane 0 is written first, lane 1 next.
  - Both valid with space ≥2: both written, wr_ptr += 2.
  - Both valid with space ==1: lane 0 written, lane 1 dropped, `overflow` set.
  - One valid: written if space ≥1, otherwise dropped and `overflow` set.
  - Lane 1 alone valid goes to the single next slot.
- Pop:
  - pop_q holds the registered `pop`; pop_evt = `pop` & ~pop_q.
  - If pop_evt and count>0: rd_ptr += 1.
  - If pop_evt with count==0: ignored, no flag.
- count_next = count + pushes − pops. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `overflow` clears only on reset.
- Display selection, `r1` registered from the head entry (all-zero data when empty):
  - `switches[3]`=0: r1 = data[4·`switches[2:0]` +: 4].
  - 4'b1000: tag[3:0].
  - 4'b1001: tag[7:4].
  - 4'b1010: count[3:0].
  - 4'b1011: {overflow, full, empty, 1'b0}.
  - 4'b1100–4'b1111: timestamp nibbles 0–3 when configured, else 4'b0000.

## Timing
- Reset values: rd_ptr=wr_ptr=0, count=0, `empty`=1, `full`=0, `overflow`=0, `r1`=0, pop_q=0, timestamp counter=0. Storage is not reset.
- Push latency: an entry written at edge N is visible in `count`/`empty` after edge N. Its nibble appears on `r1` after edge N+1 if it is the head.
- Pop latency: a rising edge of `pop` sampled at edge N advances the head at edge N; `r1` shows the new head after edge N+1.
- `switches` change to `r1` change: 1 cycle.
- Simultaneous push and pop with count==DEPTH: the pop proceeds and the push is dropped with `overflow` set, per the space rule above.
- Reset mid-operation: all state returns to reset values asynchronously. Entries are discarded and a held `pop` level produces no event until it drops and rises again.

## Configuration
- `WB_TRACE_TIMESTAMP_EN`
- Defined:
  - A 16-bit free-running cycle counter runs from reset and wraps 0xFFFF→0.
  - Each entry stores the counter value from its write cycle; both lanes in one cycle share the same stamp.
  - Switch codes 4'b1100–4'b1111 show stamp nibbles 0–3.
- Undefined: no counter, no stamp storage, and those codes show 0.

## Test plan
- Reset, then wb0 valid data=0x1234ABCD tag=5, switches=4'b0000 → after 2 cycles r1=0xD, count=1, empty=0; switches=4'b0111 → r1=0x1; 4'b1000 → r1=0x5.
- Both lanes valid for one cycle (lane0 0x11, lane1 0x22), then one pop edge → first head data[3:0]=0x1, after the pop head=0x2, count 2→1.
- Push 15 entries, then a dual push → count=16, full=1, lane 0 stored, lane 1 dropped, overflow=1; a further single push is dropped and count stays 16.
- Hold `pop` high for 10 cycles with count=4 → exactly one pop, count=3. Pop edge when empty → count stays 0 and overflow unchanged.
- Wrap-around: 40 push/pop pairs with DEPTH=16, values = index → popped sequence 0..39 in order, with no overflow.
- With `WB_TRACE_TIMESTAMP_EN`: a push on cycle 100 after reset → switches 4'b1100 shows 0x4, 4'b1101 shows 0x6. Without the macro → 0x0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo
//   Captures writeback results from two execute lanes into a small FIFO and
//   shows the head entry one nibble at a time on a 4-bit LED output.
//   Lane 0 is written before lane 1 within a cycle. Any dropped valid
//   writeback sets a sticky overflow flag.
//
// Ports
//   clk, reset (async, active-low)
//   wb0_valid/wb0_data/wb0_tag : writeback lane 0
//   wb1_valid/wb1_data/wb1_tag : writeback lane 1
//   pop      : debounced button level; each rising edge pops one entry
//   switches : display select
//   r1       : registered display nibble
//   empty, full, count, overflow : FIFO status
//
// Optional feature macro: WB_TRACE_TIMESTAMP_EN
//   When defined, a 16-bit free-running cycle counter is stored with each
//   entry and switch codes 4'b1100..4'b1111 show its nibbles.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb0_valid,
    input  logic [31:0]              wb0_data,
    input  logic [TAG_W-1:0]         wb0_tag,
    input  logic                     wb1_valid,
    input  logic [31:0]              wb1_data,
    input  logic [TAG_W-1:0]         wb1_tag,
    input  logic                     pop,
    input  logic [3:0]               switches,
    output logic [3:0]               r1,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int EW = 56;   // {stamp[15:0], tag[7:0], data[31:0]}
`else
    localparam int EW = 40;   // {tag[7:0], data[31:0]}
`endif

    logic [EW-1:0]  mem [DEPTH];

    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           pop_q;
    logic           pop_arm_q, pop_arm_d;
    logic [3:0]     r1_q, r1_d;

    logic [CW-1:0]  space;
    logic           pop_evt, do_pop, drop;
    logic [1:0]     push_n;
    logic           we0, we1;
    logic [AW-1:0]  wa0, wa1;
    logic [EW-1:0]  ent0, ent1, wd0, wd1;
    logic [EW-1:0]  head;
    logic [3:0]     count_nib;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0]    ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + 16'd1;
        ent0 = {ts_q, 8'(wb0_tag), wb0_data};
        ent1 = {ts_q, 8'(wb1_tag), wb1_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`else
    always_comb begin
        ent0 = {8'(wb0_tag), wb0_data};
        ent1 = {8'(wb1_tag), wb1_data};
    end
`endif

    // A pop edge needs pop to have been sampled low since reset, so a button
    // held through reset does not produce a spurious pop on release.
    always_comb begin
        pop_evt   = pop & ~pop_q & pop_arm_q;
        pop_arm_d = pop_arm_q | ~pop;
        do_pop    = pop_evt & (count_q != '0);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
    end

    // Space is taken from the pre-pop count: a same-cycle pop frees nothing.
    // Port 0 always takes the next slot, so a lone lane 1 result lands there.
    always_comb begin
        space  = CW'(DEPTH) - count_q;
        we0    = 1'b0;
        we1    = 1'b0;
        wa0    = wr_ptr_q;
        wa1    = wr_ptr_q + AW'(1);
        wd0    = ent0;
        wd1    = ent1;
        push_n = 2'd0;
        drop   = 1'b0;
        if (wb0_valid && wb1_valid) begin
            if (space >= CW'(2)) begin
                we0    = 1'b1;
                we1    = 1'b1;
                push_n = 2'd2;
            end else if (space == CW'(1)) begin
                we0    = 1'b1;
                push_n = 2'd1;
                drop   = 1'b1;
            end else begin
                drop   = 1'b1;
            end
        end else if (wb0_valid || wb1_valid) begin
            wd0 = wb0_valid ? ent0 : ent1;
            if (space != '0) begin
                we0    = 1'b1;
                push_n = 2'd1;
            end else begin
                drop   = 1'b1;
            end
        end
        wr_ptr_d   = wr_ptr_q + AW'(push_n);
        count_d    = count_q + CW'(push_n) - CW'(do_pop);
        overflow_d = overflow_q | drop;
    end

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        head      = empty ? '0 : mem[rd_ptr_q];
        count_nib = 4'(count_q);
        r1_d      = 4'b0000;
        if (!switches[3]) begin
            r1_d = head[{switches[2:0], 2'b00} +: 4];
        end else begin
            case (switches[2:0])
                3'b000:  r1_d = head[35:32];
                3'b001:  r1_d = head[39:36];
                3'b010:  r1_d = count_nib;
                3'b011:  r1_d = {overflow_q, full, empty, 1'b0};
`ifdef WB_TRACE_TIMESTAMP_EN
                default: r1_d = head[6'd40 + {2'b00, switches[1:0], 2'b00} +: 4];
`else
                default: r1_d = 4'b0000;
`endif
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            pop_q      <= 1'b0;
            pop_arm_q  <= 1'b0;
            r1_q       <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pop_q      <= pop;
            pop_arm_q  <= pop_arm_d;
            r1_q       <= r1_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign r1       = r1_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Testbench for wb_trace_fifo: hand-derived vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [31:0]       wb0_data = '0, wb1_data = '0;
    logic [TAG_W-1:0]  wb0_tag = '0, wb1_tag = '0;
    logic              pop = 1'b0;
    logic [3:0]        switches = '0;
    logic [3:0]        r1;
    logic              empty, full, overflow;
    logic [4:0]        count;

    wb_trace_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_data(wb0_data), .wb0_tag(wb0_tag),
        .wb1_valid(wb1_valid), .wb1_data(wb1_data), .wb1_tag(wb1_tag),
        .pop(pop), .switches(switches),
        .r1(r1), .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic [15:0] ts;
    } ent_t;

    ent_t        q[$];
    logic        m_ovf;
    int          m_last;     // last sampled pop level; 2 = none since reset
    logic [15:0] m_ts;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] disp(input logic [3:0] sw);
        ent_t        h;
        int unsigned cnt;
        logic [3:0]  nib;
        cnt = q.size();
        h = '{data: '0, tag: '0, ts: '0};
        if (cnt > 0) h = q[0];
        if (!sw[3]) return 4'(h.data >> (4 * int'(sw[2:0])));
        case (sw[2:0])
            3'd0:    nib = h.tag[3:0];
            3'd1:    nib = h.tag[7:4];
            3'd2:    nib = 4'(cnt);
            3'd3:    nib = {m_ovf, cnt == DEPTH, cnt == 0, 1'b0};
`ifdef WB_TRACE_TIMESTAMP_EN
            default: nib = 4'(h.ts >> (4 * int'(sw[1:0])));
`else
            default: nib = 4'h0;
`endif
        endcase
        return nib;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_last = 2;
        m_ts   = '0;
    endtask

    task automatic try_push(input logic [31:0] d, input logic [TAG_W-1:0] t, inout int space);
        if (space > 0) begin
            q.push_back('{data: d, tag: 8'(t), ts: m_ts});
            space--;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // One clock: model update from current inputs, edge, then compare.
    task automatic step();
        logic [3:0] exp_r1;
        int         space;
        exp_r1 = disp(switches);
        space  = DEPTH - q.size();
        if (pop && m_last == 0 && q.size() > 0) void'(q.pop_front());
        if (wb0_valid) try_push(wb0_data, wb0_tag, space);
        if (wb1_valid) try_push(wb1_data, wb1_tag, space);
        m_last = int'(pop);
        m_ts++;
        @(posedge clk); #1;
        chk("m_r1",    32'(r1),       32'(exp_r1));
        chk("m_count", 32'(count),    32'(q.size()));
        chk("m_empty", 32'(empty),    32'(q.size() == 0));
        chk("m_full",  32'(full),     32'(q.size() == DEPTH));
        chk("m_ovf",   32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle_in();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    task automatic push1(input logic [31:0] d, input logic [TAG_W-1:0] t);
        wb0_valid = 1'b1; wb0_data = d; wb0_tag = t;
        wb1_valid = 1'b0;
        step();
        idle_in();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_count", 32'(count),    32'd0);
        chk("rst_empty", 32'(empty),    32'd1);
        chk("rst_full",  32'(full),     32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_r1",    32'(r1),       32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        w0v;
        logic [31:0] w0d;
        logic [7:0]  w0t;
        logic        w1v;
        logic [31:0] w1d;
        logic [7:0]  w1t;
        logic        p;
        logic [3:0]  sw;
        logic [3:0]  e_r1;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic w0v, input logic [31:0] w0d, input logic [7:0] w0t,
                                input logic w1v, input logic [31:0] w1d, input logic [7:0] w1t,
                                input logic p, input logic [3:0] sw,
                                input logic [3:0] e_r1, input int e_cnt);
        vec_t v;
        v = '{w0v, w0d, w0t, w1v, w1d, w1t, p, sw, e_r1, e_cnt};
        return v;
    endfunction

    initial begin
        vec_t tbl[16];
        // r1 column is the value after the row's clock edge (shows pre-edge state)
        tbl[0]  = mk(1, 32'h1234ABCD, 5, 0, 0, 0,    0, 4'b0000, 4'h0, 1);
        tbl[1]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b0000, 4'hD, 1);
        tbl[2]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b0111, 4'h1, 1);
        tbl[3]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b1000, 4'h5, 1);
        tbl[4]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b1001, 4'h0, 1);
        tbl[5]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b1010, 4'h1, 1);
        tbl[6]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b1011, 4'h0, 1);
        tbl[7]  = mk(0, 0, 0,             0, 0, 0,    1, 4'b0000, 4'hD, 0);
        tbl[8]  = mk(0, 0, 0,             0, 0, 0,    0, 4'b1011, 4'h2, 0);
        tbl[9]  = mk(1, 32'h11, 1,        1, 32'h22, 2, 0, 4'b0000, 4'h0, 2);
        tbl[10] = mk(0, 0, 0,             0, 0, 0,    0, 4'b0000, 4'h1, 2);
        tbl[11] = mk(0, 0, 0,             0, 0, 0,    1, 4'b0000, 4'h1, 1);
        tbl[12] = mk(0, 0, 0,             0, 0, 0,    0, 4'b0000, 4'h2, 1);
        tbl[13] = mk(0, 0, 0,             0, 0, 0,    0, 4'b0001, 4'h2, 1);
        tbl[14] = mk(0, 0, 0,             0, 0, 0,    1, 4'b1010, 4'h1, 0);
        tbl[15] = mk(0, 0, 0,             0, 0, 0,    0, 4'b1010, 4'h0, 0);

        model_reset();
        #3;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            wb0_valid = tbl[i].w0v; wb0_data = tbl[i].w0d; wb0_tag = TAG_W'(tbl[i].w0t);
            wb1_valid = tbl[i].w1v; wb1_data = tbl[i].w1d; wb1_tag = TAG_W'(tbl[i].w1t);
            pop = tbl[i].p; switches = tbl[i].sw;
            step();
            chk($sformatf("tbl%0d_r1", i),    32'(r1),    32'(tbl[i].e_r1));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
        end
        idle_in(); pop = 1'b0; switches = 4'b0000;

        // Fill to 15, dual push with one slot left, then a push into full.
        do_reset();
        for (int i = 0; i < 15; i++) push1(32'(i), TAG_W'(i));
        wb0_valid = 1'b1; wb0_data = 32'h0F; wb1_valid = 1'b1; wb1_data = 32'h10;
        step();
        idle_in();
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_ovf",   32'(overflow), 32'd1);
        push1(32'h20, '0);
        chk("full_push_count", 32'(count), 32'd16);
        for (int k = 0; k < 16; k++) begin
            pop = 1'b0; step();
            pop = 1'b1; step();
            chk($sformatf("drain%0d_r1", k), 32'(r1), 32'(k));
        end
        pop = 1'b0; step();
        chk("drain_count", 32'(count), 32'd0);

        // Held pop gives exactly one pop; pop when empty is ignored.
        do_reset();
        for (int i = 0; i < 4; i++) push1(32'(i + 8), '0);
        pop = 1'b0; step();
        pop = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            pop = 1'b0; step();
            pop = 1'b1; step();
        end
        pop = 1'b0; step();
        pop = 1'b1; step();
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_ovf",   32'(overflow), 32'd0);
        pop = 1'b0;

        // Wrap-around: 40 push/pop pairs.
        do_reset();
        switches = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            pop = 1'b0;
            push1(32'(i), TAG_W'(i));
            pop = 1'b1; step();
            chk($sformatf("wrap%0d_r1", i), 32'(r1), 32'(i % 16));
        end
        pop = 1'b0; step();
        chk("wrap_ovf",   32'(overflow), 32'd0);
        chk("wrap_count", 32'(count), 32'd0);

        // Reset mid-operation with pop held high across it.
        do_reset();
        for (int i = 0; i < 3; i++) push1(32'(i), '0);
        pop = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_r1",    32'(r1),    32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        push1(32'hA5, '0);
        for (int i = 0; i < 3; i++) step();
        chk("midrst_held_count", 32'(count), 32'd1);
        pop = 1'b0; step();
        pop = 1'b1; step();
        chk("midrst_pop_count", 32'(count), 32'd0);
        pop = 1'b0;

        // Timestamp: entry written on cycle 100 after reset.
        do_reset();
        switches = 4'b0000;
        for (int i = 0; i < 100; i++) step();
        push1(32'hCAFE, 6'h3);
        switches = 4'b1100; step();
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts_nib0", 32'(r1), 32'h4);
`else
        chk("ts_nib0", 32'(r1), 32'h0);
`endif
        switches = 4'b1101; step();
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("ts_nib1", 32'(r1), 32'h6);
`else
        chk("ts_nib1", 32'(r1), 32'h0);
`endif

        // Randomized traffic: light then heavy push load.
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                wb0_valid = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                wb1_valid = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                wb0_data  = $urandom;
                wb1_data  = $urandom;
                wb0_tag   = TAG_W'($urandom);
                wb1_tag   = TAG_W'($urandom);
                pop       = $urandom_range(0, 1) == 1;
                switches  = 4'($urandom);
                step();
            end
        end
        idle_in(); pop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
